// File: rtl/mem_pkg.sv
// Shared types for the data-memory path: byte-op codes, fault codes and the access-unit FSM states.
package mem_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NBYTE_W = 2;
  localparam int unsigned WCNT_W  = 4;

  typedef enum logic [1:0] {
    NB_WORD = 2'b00,
    NB_BYTE = 2'b01,
    NB_HALF = 2'b10
  } nbyte_t;

  typedef enum logic [1:0] {
    F_OK       = 2'b00,
    F_MISALIGN = 2'b01,
    F_SIZE     = 2'b10,
    F_CONFLICT = 2'b11
  } fault_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } mau_state_t;

  typedef struct packed {
    logic               read;
    logic               write;
    logic [NBYTE_W-1:0] nbyte;
    logic               zext;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response channel plus data-memory strobe bus of the memory access unit.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_read;
  logic               req_write;
  logic [NBYTE_W-1:0] req_nbyte;
  logic               req_unsigned;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;

  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_W-1:0]  resp_rdata;
  logic [1:0]         resp_fault;

  logic               mem_read;
  logic               mem_write;
  logic [NBYTE_W-1:0] mem_nbyte;
  logic               mem_unsigned;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  modport slave (
    input  req_valid, req_read, req_write, req_nbyte, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    input  resp_ready,
    output mem_read, mem_write, mem_nbyte, mem_unsigned, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_read, req_write, req_nbyte, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    output resp_ready,
    input  mem_read, mem_write, mem_nbyte, mem_unsigned, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_align_check.sv
// Combinational size/alignment/conflict classifier for a memory request; shared with the fetch path.
module mem_align_check
  import mem_pkg::*;
(
  input  logic               read,
  input  logic               write,
  input  logic [NBYTE_W-1:0] nbyte,
  input  logic [1:0]         addr,
  output fault_t             fault_c
);

  // Conflict outranks size, size outranks alignment; byte accesses never misalign.
  always_comb begin
    fault_c = F_OK;
    if (read && write) begin
      fault_c = F_CONFLICT;
    end else if (nbyte == 2'b11) begin
      fault_c = F_SIZE;
    end else if (nbyte == NB_HALF && addr[0]) begin
      fault_c = F_MISALIGN;
    end else if (nbyte == NB_WORD && addr != 2'b00) begin
      fault_c = F_MISALIGN;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer: checks the request, waits, strobes memory once, responds.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus,
  output logic [CNT_W-1:0] stat_access,
  output logic [CNT_W-1:0] stat_fault
);

  mau_state_t        state, state_next;
  logic [WCNT_W-1:0] wcnt, wcnt_next;
  mem_req_t          req_q, req_in, req_next;
  fault_t            fault_c, fault_q;
  logic              accept_c;
  logic              ready_q, resp_valid_q, mem_read_q, mem_write_q;
  logic [DATA_W-1:0] rdata_q;

  mem_align_check u_align (
    .read    (bus.req_read),
    .write   (bus.req_write),
    .nbyte   (bus.req_nbyte),
    .addr    (bus.req_addr[1:0]),
    .fault_c (fault_c)
  );

  always_comb begin
    req_in.read  = bus.req_read;
    req_in.write = bus.req_write;
    req_in.nbyte = bus.req_nbyte;
    req_in.zext  = bus.req_unsigned;
    req_in.addr  = bus.req_addr;
    req_in.wdata = bus.req_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  // Faults and no-ops skip straight to the response; everything else waits then strobes once.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    accept_c   = 1'b0;
    req_next   = req_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept_c = 1'b1;
          req_next = req_in;
          if (fault_c != F_OK || (!bus.req_read && !bus.req_write)) begin
            state_next = RESP;
          end else if (WAIT_CYCLES != 0) begin
            state_next = WAIT;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      WAIT: begin
        if (wcnt == WCNT_W'(WAIT_CYCLES - 1)) begin
          state_next = ACCESS;
          wcnt_next  = '0;
        end else begin
          wcnt_next = wcnt + WCNT_W'(1);
        end
      end
      ACCESS: state_next = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and strobe outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      req_q        <= '0;
      rdata_q      <= '0;
      fault_q      <= F_OK;
      stat_access  <= '0;
      stat_fault   <= '0;
    end else begin
      ready_q      <= (state_next == IDLE);
      resp_valid_q <= (state_next == RESP);
      mem_read_q   <= (state_next == ACCESS) && req_next.read;
      mem_write_q  <= (state_next == ACCESS) && req_next.write;
      if (accept_c) begin
        req_q   <= req_next;
        rdata_q <= '0;
        fault_q <= fault_c;
        if (fault_c != F_OK && stat_fault != '1) begin
          stat_fault <= stat_fault + CNT_W'(1);
        end
      end
      if (state == ACCESS) begin
        if (req_q.read) begin
          rdata_q <= bus.mem_rdata;
        end
        if (stat_access != '1) begin
          stat_access <= stat_access + CNT_W'(1);
        end
      end
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_fault   = fault_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_nbyte    = req_q.nbyte;
  assign bus.mem_unsigned = req_q.zext;
  assign bus.mem_addr     = req_q.addr;
  assign bus.mem_wdata    = req_q.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a zero-wait unit with 4-bit stats and a three-wait-state unit, each with a memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [3:0]  sa0, sf0;
  logic [31:0] sa1, sf1;
  int n_checks = 0;
  int n_err    = 0;
  int wr_cnt0  = 0;
  int wr_cnt1  = 0;
  int wr_before;
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];

  always #5 clk = ~clk;

  mem_access_unit_if bus0 ();
  mem_access_unit_if bus1 ();

  mem_access_unit #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0.slave), .stat_access(sa0), .stat_fault(sf0)
  );
  mem_access_unit #(.WAIT_CYCLES(3), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1.slave), .stat_access(sa1), .stat_fault(sf1)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] nb, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (nb)
      2'b01:   r[{a, 3'b000} +: 8]     = wd[7:0];
      2'b10:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] nb,
                                      input logic uns, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (nb)
      2'b01:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b10:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign bus0.mem_rdata = ext(mem0[bus0.mem_addr[11:2]], bus0.mem_nbyte, bus0.mem_unsigned, bus0.mem_addr[1:0]);
  assign bus1.mem_rdata = ext(mem1[bus1.mem_addr[11:2]], bus1.mem_nbyte, bus1.mem_unsigned, bus1.mem_addr[1:0]);

  always @(posedge clk) begin
    if (bus0.mem_write) begin
      mem0[bus0.mem_addr[11:2]] <= merge(mem0[bus0.mem_addr[11:2]], bus0.mem_wdata, bus0.mem_nbyte, bus0.mem_addr[1:0]);
      wr_cnt0 <= wr_cnt0 + 1;
    end
    if (bus1.mem_write) begin
      mem1[bus1.mem_addr[11:2]] <= merge(mem1[bus1.mem_addr[11:2]], bus1.mem_wdata, bus1.mem_nbyte, bus1.mem_addr[1:0]);
      wr_cnt1 <= wr_cnt1 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req0(input logic rd, input logic wr, input logic [1:0] nb, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    bus0.req_valid = 1'b1; bus0.req_read = rd; bus0.req_write = wr; bus0.req_nbyte = nb;
    bus0.req_unsigned = uns; bus0.req_addr = a; bus0.req_wdata = wd;
  endtask

  task automatic req1(input logic rd, input logic wr, input logic [1:0] nb, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    bus1.req_valid = 1'b1; bus1.req_read = rd; bus1.req_write = wr; bus1.req_nbyte = nb;
    bus1.req_unsigned = uns; bus1.req_addr = a; bus1.req_wdata = wd;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    req0(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0); bus0.req_valid = 1'b0; bus0.resp_ready = 1'b1;
    req1(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0); bus1.req_valid = 1'b0; bus1.resp_ready = 1'b1;
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;

    // Reset state
    check("rst_req_ready",  32'(bus0.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst_mem_strobe", 32'({bus0.mem_read, bus0.mem_write}), 32'd0);
    check("rst_resp_rdata", bus0.resp_rdata, 32'd0);
    check("rst_stats",      32'({sa0, sf0}), 32'd0);
    check("rst_ready1",     32'(bus1.req_ready), 32'd1);

    // sw 0x100 <- DEADBEEF, zero wait states
    req0(1'b0, 1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF);
    tick(); bus0.req_valid = 1'b0;
    check("sw_mem_write_a1", 32'(bus0.mem_write), 32'd1);
    check("sw_mem_addr",     bus0.mem_addr, 32'h100);
    check("sw_valid_a1",     32'(bus0.resp_valid), 32'd0);
    tick();
    check("sw_valid_a2",     32'(bus0.resp_valid), 32'd1);
    check("sw_mem_write_a2", 32'(bus0.mem_write), 32'd0);
    check("sw_fault",        32'(bus0.resp_fault), 32'd0);
    check("sw_rdata",        bus0.resp_rdata, 32'd0);
    tick();
    check("sw_back_idle",    32'(bus0.req_ready), 32'd1);
    check("sw_mem_content",  mem0[32'h100 >> 2], 32'hDEADBEEF);

    // lw 0x100
    req0(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    tick(); bus0.req_valid = 1'b0;
    check("lw_mem_read_a1", 32'(bus0.mem_read), 32'd1);
    check("lw_valid_a1",    32'(bus0.resp_valid), 32'd0);
    tick();
    check("lw_valid_a2",    32'(bus0.resp_valid), 32'd1);
    check("lw_rdata",       bus0.resp_rdata, 32'hDEADBEEF);
    tick();
    check("lw_stat_access", 32'(sa0), 32'd2);

    // lh 0x103: misaligned, response next cycle, no strobe
    req0(1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
    tick(); bus0.req_valid = 1'b0;
    check("lh_valid_a1",   32'(bus0.resp_valid), 32'd1);
    check("lh_fault",      32'(bus0.resp_fault), 32'd1);
    check("lh_no_strobe",  32'({bus0.mem_read, bus0.mem_write}), 32'd0);
    check("lh_stat_fault", 32'(sf0), 32'd1);
    tick();

    // read+write with illegal size: conflict has priority
    req0(1'b1, 1'b1, 2'b11, 1'b0, 32'h101, 32'h55);
    tick(); bus0.req_valid = 1'b0;
    check("cf_fault",       32'(bus0.resp_fault), 32'd3);
    check("cf_no_strobe",   32'({bus0.mem_read, bus0.mem_write}), 32'd0);
    check("cf_stat_fault",  32'(sf0), 32'd2);
    check("cf_stat_access", 32'(sa0), 32'd2);
    tick();

    // No-op: neither read nor write
    req0(1'b0, 1'b0, 2'b00, 1'b0, 32'h200, 32'h0);
    tick(); bus0.req_valid = 1'b0;
    check("noop_valid_a1",   32'(bus0.resp_valid), 32'd1);
    check("noop_fault",      32'(bus0.resp_fault), 32'd0);
    check("noop_stat_fault", 32'(sf0), 32'd2);
    tick();
    check("dut0_write_count", 32'(wr_cnt0), 32'd1);

    // Saturation of the 4-bit access counter
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    check("sat_cleared", 32'(sa0), 32'd0);
    for (int i = 0; i < 15; i++) begin
      req0(1'b0, 1'b1, 2'b00, 1'b0, 32'h10 + 32'(4 * i), 32'(i));
      tick(); bus0.req_valid = 1'b0;
      tick(); tick();
    end
    check("sat_15", 32'(sa0), 32'd15);
    req0(1'b0, 1'b1, 2'b00, 1'b0, 32'h80, 32'h1);
    tick(); bus0.req_valid = 1'b0;
    tick(); tick();
    check("sat_16", 32'(sa0), 32'd15);

    // sb 0x200 <- 0x80 with three wait states
    req1(1'b0, 1'b1, 2'b01, 1'b0, 32'h200, 32'h12345680);
    tick(); bus1.req_valid = 1'b0;
    check("sb_wait_no_strobe", 32'(bus1.mem_write), 32'd0);
    tick(); tick();
    check("sb_wait3_no_strobe", 32'(bus1.mem_write), 32'd0);
    tick();
    check("sb_strobe_a4", 32'(bus1.mem_write), 32'd1);
    tick();
    check("sb_valid_a5",  32'(bus1.resp_valid), 32'd1);
    tick();

    // lbu 0x200 with consumer stalled for four cycles
    bus1.resp_ready = 1'b0;
    req1(1'b1, 1'b0, 2'b01, 1'b1, 32'h200, 32'h0);
    tick(); bus1.req_valid = 1'b0;
    tick(); tick(); tick();
    check("lbu_valid_a4", 32'(bus1.resp_valid), 32'd0);
    check("lbu_read_a4",  32'(bus1.mem_read), 32'd1);
    tick();
    check("lbu_valid_a5", 32'(bus1.resp_valid), 32'd1);
    check("lbu_rdata_a5", bus1.resp_rdata, 32'h00000080);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lbu_hold_valid", 32'(bus1.resp_valid), 32'd1);
      check("lbu_hold_rdata", bus1.resp_rdata, 32'h00000080);
      check("lbu_hold_ready", 32'(bus1.req_ready), 32'd0);
    end
    bus1.resp_ready = 1'b1;
    tick();
    check("lbu_back_idle", 32'(bus1.req_ready), 32'd1);
    check("lbu_stat_access", sa1, 32'd2);

    // Reset during WAIT of a store: nothing reaches memory
    wr_before = wr_cnt1;
    req1(1'b0, 1'b1, 2'b00, 1'b0, 32'h300, 32'hCAFEF00D);
    tick(); bus1.req_valid = 1'b0;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check("rstw_ready",   32'(bus1.req_ready), 32'd1);
    check("rstw_valid",   32'(bus1.resp_valid), 32'd0);
    tick(); tick(); tick(); tick();
    check("rstw_no_write", 32'(wr_cnt1), 32'(wr_before));
    check("rstw_stat",     sa1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
